aes_pipe_ctrl: RTL
==================

AES_PIPE_CTRL -- requirements
Module: aes_pipe_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, is the number of registered round stages sequenced (14 for AES-256).
REQ-002 Parameter CREDITS, default 16, is the downstream result-buffer depth.
REQ-003 Parameter CNT_W, default 5, is the credit counter width and SHALL hold CREDITS.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 key_start  in  1  single-cycle request to load a new key.
REQ-007 key_go  out  1  single-cycle start pulse to the key expander.
REQ-008 key_done  in  1  single-cycle pulse from the key expander when round keys are stable.
REQ-009 in_valid  in  1  plaintext block present at round-1 input.
REQ-010 in_ready  out  1  controller accepts a block this cycle.
REQ-011 round_en  out  NUM_ROUNDS  enable of each round register; bit k drives round k+1.
REQ-012 out_valid  out  1  final-round register holds a valid ciphertext.
REQ-013 out_pop  in  1  downstream buffer released one entry.
REQ-014 flush  in  1  synchronous abort of all in-flight blocks.
REQ-015 credits  out  CNT_W  free downstream entries.
REQ-016 busy  out  1  key load, drain or in-flight block present.
REQ-017 cred_err  out  1  sticky; out_pop seen while credits == CREDITS.

Function
REQ-018 States: IDLE, KEY, RUN, DRAIN; reset state IDLE.
REQ-019 IDLE: key_start -> KEY; key_go SHALL pulse exactly in the first cycle of KEY.
REQ-020 KEY: key_done -> RUN; in_ready = 0 throughout KEY.
REQ-021 RUN: in_ready = credits != 0 && !flush; accept = in_valid && in_ready.
REQ-022 round_en[0] = accept (combinational); internal vld[k] <= round_en[k] each cycle; round_en[k] = vld[k-1] for k >= 1.
REQ-023 out_valid = vld[NUM_ROUNDS-1]; latency: block accepted in cycle t gives out_valid in cycle t+NUM_ROUNDS.
REQ-024 Back-to-back accepts SHALL yield one out_valid per cycle; gaps propagate as disabled (zeroed) stages.
REQ-025 RUN with key_start -> DRAIN; DRAIN: in_ready = 0; when all vld bits are 0 -> KEY (key_go pulses).
REQ-026 key_start in KEY or DRAIN SHALL be ignored.
REQ-027 credits: -1 on accept, +1 on out_pop, unchanged when both occur in the same cycle.
REQ-028 out_pop at credits == CREDITS (without accept) SHALL leave credits unchanged and set cred_err.
REQ-029 flush, in any state: next cycle vld = 0, credits = CREDITS, state = IDLE if in KEY or DRAIN, otherwise unchanged; flush dominates key_start, key_done and out_pop.
REQ-030 busy = (state == KEY) || (state == DRAIN) || (vld != 0).

Reset
REQ-031 On rst low, asynchronously: state = IDLE, vld = 0, credits = CREDITS, cred_err = 0, key_go = 0.
REQ-032 Reset mid-operation SHALL discard in-flight blocks; the outputs round_en = 0, out_valid = 0 and in_ready = 0 SHALL hold while rst is low.

Structure
REQ-033 The state encoding and defaults for NUM_ROUNDS and CREDITS SHALL live in a shared AES package.
REQ-034 The credit counter SHALL be a sub-module aes_credit_cnt (init, inc, dec, flush, err).
REQ-035 The round datapath and key expander SHALL remain outside this block.

Verification
REQ-036 Reset, key_start, key_done after 3 cycles, then 1 block -> key_go pulses once; out_valid exactly 10 cycles after accept; credits 16->15.
REQ-037 Run 20 back-to-back blocks with no out_pop -> in_ready drops after 16 accepts; credits = 0; one out_pop -> exactly one more accept.
REQ-038 Issue key_start with 4 blocks in flight -> in_ready = 0; all 4 out_valid; key_go pulses on the cycle after the last vld bit clears.
REQ-039 Drive accept and out_pop in the same cycle at credits = 7 -> credits stays 7.
REQ-040 Assert flush with 5 blocks in flight -> round_en = 0 and out_valid = 0 next cycle; credits = 16.
REQ-041 Assert rst low in RUN with blocks in flight, and separately out_pop at credits = 16 -> all outputs take reset values; cred_err = 1, credits = 16.

Source files
------------

// File: rtl/aes_pipe_ctrl_pkg.sv
// ============================================================================
//  aes_pipe_ctrl_pkg : shared AES controller types and parameter defaults
//  Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pipe_ctrl_pkg;

    localparam int AES_NUM_ROUNDS = 10;
    localparam int AES_CREDITS    = 16;
    localparam int AES_CNT_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KEY   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/aes_pipe_ctrl_if.sv
// ============================================================================
//  aes_pipe_ctrl_if : handshake / status bundle between AES controller and system
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface aes_pipe_ctrl_if
    import aes_pipe_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int CNT_W      = AES_CNT_W
) ();

    logic                  key_start;
    logic                  key_go;
    logic                  key_done;
    logic                  in_valid;
    logic                  in_ready;
    logic [NUM_ROUNDS-1:0] round_en;
    logic                  out_valid;
    logic                  out_pop;
    logic                  flush;
    logic [CNT_W-1:0]      credits;
    logic                  busy;
    logic                  cred_err;

    // System side: requests keys, offers blocks, releases buffer entries.
    modport master (
        output key_start, key_done, in_valid, out_pop, flush,
        input  key_go, in_ready, round_en, out_valid, credits, busy, cred_err
    );

    modport slave (
        input  key_start, key_done, in_valid, out_pop, flush,
        output key_go, in_ready, round_en, out_valid, credits, busy, cred_err
    );

endinterface

`default_nettype wire

// File: rtl/aes_credit_cnt.sv
// ============================================================================
//  aes_credit_cnt : downstream result-buffer credit counter with sticky overflow
//  Revision: 1.0
// ============================================================================
`default_nettype none

module aes_credit_cnt
    import aes_pipe_ctrl_pkg::*;
#(
    parameter int INIT  = AES_CREDITS,
    parameter int CNT_W = AES_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc_i,
    input  wire logic             dec_i,
    input  wire logic             flush_i,
    output logic [CNT_W-1:0]      cnt_o,
    output logic                  err_o
);

    localparam logic [CNT_W-1:0] C_INIT = CNT_W'(INIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // A release with the buffer already fully free is a protocol error:
    // count is held and the error latches until reset.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (flush_i) begin
            cnt_d = C_INIT;
        end else if (inc_i && !dec_i) begin
            if (cnt_q == C_INIT) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= C_INIT;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

`default_nettype wire

// File: rtl/aes_pipe_ctrl.sv
// ============================================================================
//  aes_pipe_ctrl : key-load sequencing, round-stage enables and credit flow
//                  control for an iterative-unrolled AES pipeline
//  Revision: 1.0
// ============================================================================
`default_nettype none

module aes_pipe_ctrl
    import aes_pipe_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int CREDITS    = AES_CREDITS,
    parameter int CNT_W      = AES_CNT_W
) (
    input  wire logic      clk,
    input  wire logic      rst,      // asynchronous, active-low
    aes_pipe_ctrl_if.slave bus
);

    ctrl_state_e           state_q;
    logic                  key_go_q;
    logic [NUM_ROUNDS-1:0] vld_q, vld_d;
    logic [NUM_ROUNDS-1:0] round_en;
    logic                  in_ready;
    logic                  accept;
    logic [CNT_W-1:0]      credits;
    logic                  cred_err;

    assign in_ready = (state_q == ST_RUN) && (credits != '0) && !bus.flush;
    assign accept   = bus.in_valid && in_ready;

    // Stage k+1 is enabled exactly when stage k held a valid block last cycle.
    generate
        if (NUM_ROUNDS > 1) begin : g_multi_round
            assign round_en = {vld_q[NUM_ROUNDS-2:0], accept};
        end else begin : g_single_round
            assign round_en = accept;
        end
    endgenerate

    assign vld_d = bus.flush ? '0 : round_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // key_go is registered on every entry into KEY so it lines up with
    // the first KEY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            key_go_q <= 1'b0;
        end else begin
            key_go_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!bus.flush && bus.key_start) begin
                        state_q  <= ST_KEY;
                        key_go_q <= 1'b1;
                    end
                end
                ST_KEY: begin
                    if (bus.flush) begin
                        state_q <= ST_IDLE;
                    end else if (bus.key_done) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!bus.flush && bus.key_start) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.flush) begin
                        state_q <= ST_IDLE;
                    end else if (vld_q == '0) begin
                        state_q  <= ST_KEY;
                        key_go_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    aes_credit_cnt #(
        .INIT  (CREDITS),
        .CNT_W (CNT_W)
    ) u_credit_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (bus.out_pop),
        .dec_i   (accept),
        .flush_i (bus.flush),
        .cnt_o   (credits),
        .err_o   (cred_err)
    );

    assign bus.key_go    = key_go_q;
    assign bus.in_ready  = in_ready;
    assign bus.round_en  = round_en;
    assign bus.out_valid = vld_q[NUM_ROUNDS-1];
    assign bus.credits   = credits;
    assign bus.cred_err  = cred_err;
    assign bus.busy      = (state_q == ST_KEY) || (state_q == ST_DRAIN) || (vld_q != '0);

endmodule

`default_nettype wire
